// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage. Issues one instruction-memory read per
//            instruction, holds the returned word for the controller until it
//            is retired, and computes the next PC (sequential or redirected).
//            Misaligned redirects and memory timeouts park the unit in a
//            sticky error state until reset.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCsrc,
  input  logic [31:0] PCTarget,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instrc,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] instr_count
);

  localparam logic [31:0] c_nop      = 32'h0000_0013;
  localparam logic [7:0]  c_max_wait = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;

  logic [31:0] w_pc_plus4;
  logic        w_target_misaligned;

  // Sequential PC wraps naturally at 2^32; a redirect is only legal when
  // word aligned.
  assign w_pc_plus4          = pc_q + 32'd4;
  assign w_target_misaligned = PCsrc && (PCTarget[1:0] != 2'b00);

  // State and datapath registers; reset also discards any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= c_nop;
      cnt_q   <= 32'd0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic: memory handshake in FETCH, retire/redirect in HOLD.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        wait_d  = 8'd0;
      end

      FETCH: begin
        // A response on the last allowed cycle still counts as a hit.
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = HOLD;
        end else if (wait_q == c_max_wait) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      HOLD: begin
        if (advance) begin
          // The instruction retires even when its redirect is unusable.
          cnt_d = cnt_q + 32'd1;
          if (w_target_misaligned) begin
            state_d = ERR;
          end else begin
            pc_d    = PCsrc ? PCTarget : w_pc_plus4;
            wait_d  = 8'd0;
            state_d = FETCH;
          end
        end
      end

      ERR: begin
        state_d = ERR;
      end

      default: begin
        state_d = ERR;
      end
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign PCPlus4     = w_pc_plus4;
  assign instr_valid = (state_q == HOLD);
  assign Instrc      = instr_valid ? ir_q : c_nop;
  assign fetch_err   = (state_q == ERR);
  assign instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit. A transaction-level model
//            (expected PC, retire count, error flag) predicts every output;
//            memory latency, held instructions and redirects are randomized.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MW     = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        PCsrc;
  logic [31:0] PCTarget;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instrc;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        fetch_err;
  logic [31:0] instr_count;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .MAX_WAIT (MW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCsrc       (PCsrc),
    .PCTarget    (PCTarget),
    .advance     (advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .Instrc      (Instrc),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs expected while a request is outstanding.
  task automatic chk_fetching();
    chk("fetch_req",   {31'd0, imem_req},    32'd1);
    chk("fetch_addr",  imem_addr,            exp_pc);
    chk("fetch_pc",    PC,                   exp_pc);
    chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
    chk("fetch_instr", Instrc,               NOP);
    chk("fetch_err",   {31'd0, fetch_err},   32'd0);
    chk("fetch_count", instr_count,          exp_cnt);
  endtask

  // Serve one fetch whose data arrives after d empty wait cycles.
  task automatic fetch(input int d, input logic [31:0] word);
    for (int k = 0; k <= d; k++) begin
      chk_fetching();
      imem_ready = (k == d);
      imem_rdata = (k == d) ? word : $urandom;
      advance    = 1'($urandom);
      PCsrc      = 1'($urandom);
      PCTarget   = $urandom;
      @(negedge clk);
    end
    imem_ready = 1'b0;
    advance    = 1'b0;
  endtask

  // Present the word for 'extra' idle cycles, then retire it.
  task automatic hold_retire(input int extra, input logic src, input logic [31:0] tgt,
                             input logic [31:0] word);
    for (int i = 0; i <= extra; i++) begin
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_instr", Instrc,               word);
      chk("hold_pc",    PC,                   exp_pc);
      chk("hold_pc4",   PCPlus4,              exp_pc + 32'd4);
      chk("hold_req",   {31'd0, imem_req},    32'd0);
      chk("hold_err",   {31'd0, fetch_err},   32'd0);
      chk("hold_count", instr_count,          exp_cnt);
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      if (i == extra) begin
        advance  = 1'b1;
        PCsrc    = src;
        PCTarget = tgt;
      end else begin
        advance  = 1'b0;
        PCsrc    = 1'($urandom);
        PCTarget = $urandom;
      end
      @(negedge clk);
    end
    advance    = 1'b0;
    imem_ready = 1'b0;
    exp_cnt    = exp_cnt + 32'd1;
    if (!(src && tgt[1:0] != 2'b00))
      exp_pc = src ? tgt : exp_pc + 32'd4;
  endtask

  // Error state must hold regardless of inputs.
  task automatic chk_err(input int n);
    for (int i = 0; i < n; i++) begin
      chk("err_flag",  {31'd0, fetch_err},   32'd1);
      chk("err_req",   {31'd0, imem_req},    32'd0);
      chk("err_valid", {31'd0, instr_valid}, 32'd0);
      chk("err_instr", Instrc,               NOP);
      chk("err_pc",    PC,                   exp_pc);
      chk("err_count", instr_count,          exp_cnt);
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      advance    = 1'($urandom);
      PCsrc      = 1'($urandom);
      PCTarget   = $urandom;
      @(negedge clk);
    end
    imem_ready = 1'b0;
    advance    = 1'b0;
  endtask

  // Reset asserted between edges; then the single BOOT cycle with stray
  // memory responses present.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = $urandom;
    advance    = 1'b1;
    PCsrc      = 1'b0;
    #1;
    exp_pc  = RST_PC;
    exp_cnt = 32'd0;
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", Instrc,               NOP);
    chk("rst_pc",    PC,                   RST_PC);
    chk("rst_pc4",   PCPlus4,              RST_PC + 32'd4);
    chk("rst_err",   {31'd0, fetch_err},   32'd0);
    chk("rst_count", instr_count,          32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_req",   {31'd0, imem_req},    32'd0);
    chk("boot_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] tgt;
    int          d;
    int          extra;
    logic        src;

    rst_n      = 1'b0;
    PCsrc      = 1'b0;
    PCTarget   = 32'd0;
    advance    = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    exp_pc     = RST_PC;
    exp_cnt    = 32'd0;

    // Sequential fetch 0,4,8,C with a zero-wait memory.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      w = $urandom;
      fetch(0, w);
      hold_retire(0, 1'b0, 32'd0, w);
    end
    chk("seq_count4", instr_count, 32'd4);
    chk("seq_pc10",   imem_addr,   32'h10);

    // Branch taken while holding PC=8; 0xC must never be requested.
    do_reset();
    for (int n = 0; n < 2; n++) begin
      w = $urandom;
      fetch(0, w);
      hold_retire(0, 1'b0, 32'd0, w);
    end
    w = $urandom;
    fetch(0, w);
    hold_retire(1, 1'b1, 32'h100, w);
    chk("branch_addr", imem_addr, 32'h100);
    w = $urandom;
    fetch(2, w);
    hold_retire(0, 1'b0, 32'd0, w);

    // Wait states: 3 cycles, then exactly MAX_WAIT, then MAX_WAIT+1.
    w = $urandom;
    fetch(3, w);
    hold_retire(0, 1'b0, 32'd0, w);
    w = $urandom;
    fetch(MW, w);
    hold_retire(0, 1'b0, 32'd0, w);
    for (int k = 0; k <= MW; k++) begin
      chk_fetching();
      imem_ready = 1'b0;
      advance    = 1'($urandom);
      @(negedge clk);
    end
    chk_err(4);

    // Randomized traffic: latency, hold time and aligned redirects.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      d     = $urandom_range(0, MW);
      extra = $urandom_range(0, 2);
      src   = 1'($urandom);
      tgt   = $urandom & 32'hFFFF_FFFC;
      w     = $urandom;
      fetch(d, w);
      hold_retire(extra, src, tgt, w);
    end

    // PC+4 wrap from the top of the address space.
    w = $urandom;
    fetch(0, w);
    hold_retire(0, 1'b1, 32'hFFFF_FFFC, w);
    w = $urandom;
    fetch(1, w);
    chk("wrap_pc4", PCPlus4, 32'h0000_0000);
    hold_retire(0, 1'b0, 32'd0, w);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_err",  {31'd0, fetch_err}, 32'd0);
    w = $urandom;
    fetch(0, w);
    hold_retire(0, 1'b0, 32'd0, w);

    // Misaligned redirect: retire counts, PC frozen, unit parks in error.
    do_reset();
    w = $urandom;
    fetch(0, w);
    hold_retire(0, 1'b0, 32'd0, w);
    w = $urandom;
    fetch(1, w);
    hold_retire(0, 1'b1, 32'h102, w);
    chk("mis_pc",    PC,          32'h4);
    chk("mis_count", instr_count, 32'd2);
    chk_err(5);

    // Asynchronous reset in the middle of an outstanding fetch.
    do_reset();
    w = $urandom;
    fetch(0, w);
    hold_retire(0, 1'b0, 32'd0, w);
    for (int k = 0; k < 2; k++) begin
      chk_fetching();
      imem_ready = 1'b0;
      @(negedge clk);
    end
    do_reset();
    w = $urandom;
    fetch(1, w);
    hold_retire(0, 1'b0, 32'd0, w);
    chk("post_rst_count", instr_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
